imem_boot_loader: RTL

Boot-time instruction-memory loader upstream of the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and parses a 16-bit word-count header. Each group of four payload bytes is packed little-endian into a 32-bit word and written to instruction memory at consecutive word addresses. The core is held in reset until loading completes successfully.

---
 rtl/imem_boot_loader_pkg.sv | 26 ++
 rtl/imem_word_packer.sv | 48 ++++
 rtl/imem_boot_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_boot_loader_pkg                                                 |
// | State encoding and framing constants for the boot-time IMEM loader.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO  = 3'd0,
    HDR_HI  = 3'd1,
    PAYLOAD = 3'd2,
    CHK     = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic accepts_bytes(input state_e s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == PAYLOAD) || (s == CHK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_word_packer                                                     |
// | Packs four bytes little-endian into a word; pulses word_valid_o once.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_word_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        take_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic        last_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  idx_q;
  logic [31:0] data_q;
  logic        valid_q;

  // Right-shifting in each byte leaves the first byte in [7:0] after four takes.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= take_i && (idx_q == LAST_IDX);
      if (take_i) begin
        data_q <= {byte_i, data_q[31:8]};
        idx_q  <= idx_q + 2'd1;
      end else if (clear_i) begin
        idx_q <= 2'd0;
      end
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = data_q;
  assign last_o       = (idx_q == LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_boot_loader                                                     |
// | Byte-stream IMEM loader holding the core in reset until load is done.|
// | Optional trailing XOR checksum: IMEM_BOOT_LOADER_CHECKSUM_EN.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BYTE_VALID,
  input  logic [7:0]        BYTE_DATA,
  output logic              BYTE_READY,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic              CORE_RST,
  output logic              LOAD_DONE,
  output logic              LOAD_ERR
);

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_e            state_q, state_d;
  state_e            after_payload;
  logic [15:0]       count_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              byte_ready;
  logic              take;
  logic              pk_take, pk_clear, pk_last, pk_valid;
  logic [31:0]       pk_word;
  logic [15:0]       hdr_count;
  logic              last_word;

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  assign after_payload = CHK;
`else
  assign after_payload = DONE;
`endif

  assign take      = BYTE_VALID && byte_ready;
  assign hdr_count = {BYTE_DATA, count_q[7:0]};
  assign last_word = (17'(word_cnt_q) + 17'd1) == {1'b0, count_q};
  assign pk_take   = take && (state_q == PAYLOAD);
  assign pk_clear  = (state_q != PAYLOAD);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= HDR_LO;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR_LO:  if (take) state_d = HDR_HI;
      HDR_HI: begin
        if (take) begin
          if (hdr_count == 16'd0)                 state_d = after_payload;
          else if ({1'b0, hdr_count} > MAX_WORDS) state_d = ERR;
          else                                    state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (pk_take && pk_last && last_word) state_d = after_payload;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      CHK:     if (take) state_d = (BYTE_DATA == chk_q) ? DONE : ERR;
`endif
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    byte_ready = accepts_bytes(state_q);
    core_rst_d = (state_q != DONE);
    done_d     = (state_q == DONE);
    err_d      = (state_q == ERR);
  end

  // Status lags the state by one cycle so the final write lands before the core runs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q    <= 16'd0;
      word_cnt_q <= '0;
      addr_q     <= '0;
    end else begin
      if (take && (state_q == HDR_LO)) count_q[7:0]  <= BYTE_DATA;
      if (take && (state_q == HDR_HI)) count_q[15:8] <= BYTE_DATA;
      if (pk_take && pk_last) begin
        addr_q     <= word_cnt_q[ADDR_W-1:0];
        word_cnt_q <= word_cnt_q + (ADDR_W+1)'(1);
      end
    end
  end

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (RST)          chk_q <= 8'd0;
    else if (pk_take) chk_q <= chk_q ^ BYTE_DATA;
  end
`endif

  imem_word_packer u_packer (
    .clk          (CLK),
    .rst          (RST),
    .take_i       (pk_take),
    .clear_i      (pk_clear),
    .byte_i       (BYTE_DATA),
    .word_valid_o (pk_valid),
    .word_o       (pk_word),
    .last_o       (pk_last)
  );

  assign BYTE_READY = byte_ready;
  assign IMEM_WE    = pk_valid;
  assign IMEM_ADDR  = addr_q;
  assign IMEM_WDATA = pk_word;
  assign CORE_RST   = core_rst_q;
  assign LOAD_DONE  = done_q;
  assign LOAD_ERR   = err_q;

endmodule
`default_nettype wire
